// File: rtl/mse_batch_eval_if.sv
// mse_batch_eval_if: control, sample and result handshake bundle
// for the batch squared-error evaluation engine.
interface mse_batch_eval_if #(
   parameter int NUM_LANES = 2,
   parameter int DATA_WL   = 12,
   parameter int ACC_WL    = 64,
   parameter int CNT_WL    = 24
);
   localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   logic                           start;
   logic [CNT_WL-1:0]              num_samples;
   logic [CNT_WL-1:0]              skip;
   logic                           in_valid;
   logic [NUM_LANES*DATA_WL-1:0]   data_in;
   logic [DATA_WL-1:0]             data_ref;
   logic                           busy;
   logic                           res_valid;
   logic                           res_ready;
   logic [LW-1:0]                  res_lane;
   logic [ACC_WL-1:0]              res_data;
   logic                           res_sat;
   logic                           done;

   modport master (
      output start, num_samples, skip, in_valid, data_in, data_ref,
      output res_ready,
      input  busy, res_valid, res_lane, res_data, res_sat, done
   );

   modport slave (
      input  start, num_samples, skip, in_valid, data_in, data_ref,
      input  res_ready,
      output busy, res_valid, res_lane, res_data, res_sat, done
   );
endinterface

// File: rtl/mse_batch_eval.sv
// mse_batch_eval: per-lane saturating sum of squared errors against a
// shared reference, with warm-up skip and lane-serial result readout.
module mse_batch_eval #(
   parameter int NUM_LANES = 2,
   parameter int DATA_WL   = 12,
   parameter int ACC_WL    = 64,
   parameter int CNT_WL    = 24
) (
   input  logic             clk,
   input  logic             rst,
   mse_batch_eval_if.slave  bus
);
   localparam int LW  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int DW  = DATA_WL + 1;
   localparam int SQW = 2 * DW;
   localparam int SW  = ((ACC_WL > SQW) ? ACC_WL : SQW) + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SKIP   = 3'd1;
   localparam logic [2:0] S_ACCUM  = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_OUTPUT = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [CNT_WL-1:0] cnt_q, cnt_d;
   logic [CNT_WL-1:0] skp_q, skp_d;
   logic [LW-1:0]     lane_q, lane_d;
   logic              drn_q, drn_d;
   logic              done_q, done_d;
   logic              inject, clr;
   logic              v1_q, v2_q;
   logic              out_v;

   logic signed [DW-1:0] diff_d [NUM_LANES];
   logic signed [DW-1:0] diff_q [NUM_LANES];
   logic [SQW-1:0]       sq_d   [NUM_LANES];
   logic [SQW-1:0]       sq_q   [NUM_LANES];
   logic [ACC_WL-1:0]    acc_d  [NUM_LANES];
   logic [ACC_WL-1:0]    acc_q  [NUM_LANES];
   logic [SW-1:0]        sum    [NUM_LANES];
   logic [NUM_LANES-1:0] sat_d, sat_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      skp_d   = skp_q;
      lane_d  = lane_q;
      drn_d   = drn_q;
      done_d  = 1'b0;
      inject  = 1'b0;
      clr     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               clr    = 1'b1;
               cnt_d  = bus.num_samples;
               skp_d  = bus.skip;
               lane_d = '0;
               if (bus.num_samples == '0)
                  state_d = S_OUTPUT;
               else if (bus.skip == '0)
                  state_d = S_ACCUM;
               else
                  state_d = S_SKIP;
            end
         end
         S_SKIP: begin
            if (bus.in_valid) begin
               skp_d = skp_q - CNT_WL'(1);
               if (skp_q == CNT_WL'(1))
                  state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (bus.in_valid) begin
               inject = 1'b1;
               cnt_d  = cnt_q - CNT_WL'(1);
               if (cnt_q == CNT_WL'(1)) begin
                  state_d = S_DRAIN;
                  drn_d   = 1'b0;
               end
            end
         end
         S_DRAIN: begin
            drn_d = 1'b1;
            if (drn_q)
               state_d = S_OUTPUT;
         end
         S_OUTPUT: begin
            if (bus.res_ready) begin
               if (lane_q == LW'(NUM_LANES - 1)) begin
                  state_d = S_IDLE;
                  lane_d  = '0;
                  done_d  = 1'b1;
               end else begin
                  lane_d = lane_q + LW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Widened sum so the saturation test also covers ACC_WL narrower than sq.
   always_comb begin
      sat_d = sat_q;
      for (int k = 0; k < NUM_LANES; k++) begin
         diff_d[k] = DW'($signed(bus.data_in[k*DATA_WL +: DATA_WL]))
                   - DW'($signed(bus.data_ref));
         sq_d[k]   = $unsigned(SQW'(diff_q[k]) * SQW'(diff_q[k]));
         sum[k]    = SW'(acc_q[k]) + SW'(sq_q[k]);
         acc_d[k]  = acc_q[k];
         if (clr) begin
            acc_d[k] = '0;
            sat_d[k] = 1'b0;
         end else if (v2_q) begin
            if (sum[k][SW-1:ACC_WL] != '0) begin
               acc_d[k] = '1;
               sat_d[k] = 1'b1;
            end else begin
               acc_d[k] = sum[k][ACC_WL-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         skp_q   <= '0;
         lane_q  <= '0;
         drn_q   <= 1'b0;
         done_q  <= 1'b0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         sat_q   <= '0;
         for (int k = 0; k < NUM_LANES; k++) begin
            diff_q[k] <= '0;
            sq_q[k]   <= '0;
            acc_q[k]  <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         skp_q   <= skp_d;
         lane_q  <= lane_d;
         drn_q   <= drn_d;
         done_q  <= done_d;
         v1_q    <= inject;
         v2_q    <= v1_q;
         sat_q   <= sat_d;
         acc_q   <= acc_d;
         if (inject) diff_q <= diff_d;
         if (v1_q)   sq_q   <= sq_d;
      end
   end

   assign out_v         = (state_q == S_OUTPUT);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.res_valid = out_v;
   assign bus.res_lane  = lane_q;
   assign bus.res_data  = out_v ? acc_q[lane_q] : '0;
   assign bus.res_sat   = out_v & sat_q[lane_q];
   assign bus.done      = done_q;
endmodule
